wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have these ports; the clock and reset are listed first:
  clk_i  in  1  single clock; all state updates on its rising edge.
  rst_n_i  in  1  asynchronous active-low reset.
  RegWrite_i  in  1  write-back enable from MEM/WB stage.
  MemToReg_i  in  1  write-back source select: 1 = Data_i, 0 = Result_i.
  Data_i  in  32  memory load data from MEM/WB stage.
  Result_i  in  32  ALU result from MEM/WB stage.
  RD_i  in  5  destination register index.
  RS_addr_i  in  5  read port A index.
  RT_addr_i  in  5  read port B index.
  RS_data_o  out  32  read port A data.
  RT_data_o  out  32  read port B data.
  WB_data_o  out  32  selected write-back value, for EX-stage forwarding.
  written_mask_o  out  32  bit n = register n written since reset.
  wr_count_o  out  32  count of committed register writes.
REQ-002 SHALL use one clock, clk_i, with an asynchronous, active-low reset, rst_n_i.

Function
REQ-003 SHALL drive WB_data_o combinationally: MemToReg_i ? Data_i : Result_i.
REQ-004 SHALL hold 32 registers x 32 bits; register 0 SHALL read as 0 at all times.
REQ-005 A commit SHALL occur on a rising edge of clk_i when rst_n_i=1, RegWrite_i=1 and RD_i!=0.
REQ-006 On a commit, reg[RD_i] SHALL take WB_data_o, and the write SHALL be visible on the read ports from the next cycle (1-cycle write latency).
REQ-007 RegWrite_i=1 with RD_i=0 SHALL NOT change any state: no register write, no mask change, no count increment.
REQ-008 Read ports SHALL be combinational (0-cycle latency); RS_addr_i=0 or RT_addr_i=0 SHALL return 32'h0.
REQ-009 RS and RT SHALL be independent; both ports reading the same index SHALL return identical data.
REQ-010 On each commit, written_mask_o[RD_i] SHALL set to 1; bit 0 SHALL be constant 1.
REQ-011 On each commit, wr_count_o SHALL increment by 1, modulo 2^32 (32'hFFFFFFFF wraps to 0).
REQ-012 Back-to-back commits to the same RD_i SHALL each count; the last value wins.

Reset
REQ-013 While rst_n_i=0, the block SHALL hold these values, applied immediately without waiting for a clock edge: all registers 0, written_mask_o=32'h00000001, wr_count_o=0.
REQ-014 A rising edge of clk_i while rst_n_i=0 SHALL NOT commit, even if RegWrite_i=1.
REQ-015 A reset asserted mid-operation SHALL discard the pending write; the first commit after reset SHALL be the first rising edge with rst_n_i=1.
REQ-016 WB_data_o SHALL stay purely combinational and SHALL NOT be affected by reset.

Configuration
REQ-017 Macro WB_REGFILE_BYPASS_EN defined: a read port whose address equals RD_i while RegWrite_i=1, RD_i!=0 and rst_n_i=1 SHALL return WB_data_o in the same cycle (write-through).
REQ-018 Macro WB_REGFILE_BYPASS_EN undefined: such a read SHALL return the stored pre-write value; the new value SHALL appear next cycle.
REQ-019 The interface, reset behaviour and counters SHALL be identical in both builds.

Verification
REQ-020 Reset, then read all 32 indices -> all data 0, written_mask_o=32'h00000001, wr_count_o=0.
REQ-021 RegWrite_i=1, MemToReg_i=1, Data_i=32'hDEADBEEF, Result_i=32'h12345678, RD_i=5; read RS_addr_i=5 next cycle -> RS_data_o=32'hDEADBEEF, mask bit 5=1, wr_count_o=1.
REQ-022 RegWrite_i=1, RD_i=0, Result_i=32'hFFFFFFFF, MemToReg_i=0 -> RS/RT at addr 0 read 0, wr_count_o unchanged.
REQ-023 Same-cycle write RD_i=7 value 32'hA5A5A5A5 while RT_addr_i=7, old value 32'h1:
  - bypass build -> RT_data_o=32'hA5A5A5A5 that cycle.
  - non-bypass build -> RT_data_o=32'h1 that cycle, then 32'hA5A5A5A5.
REQ-024 Force wr_count_o to 32'hFFFFFFFF via hierarchical preload, then commit once -> wr_count_o=0.
REQ-025 Assert rst_n_i low between clock edges with RegWrite_i=1, RD_i=3 pending -> outputs clear immediately, reg 3 stays 0 after release until the next commit.

Source files
------------

// File: rtl/wb_regfile.sv
// MEM/WB write-back register file: 31 writable 32-bit registers, two combinational read ports, write tracking.
// Optional same-cycle write-through on the read ports when WB_REGFILE_BYPASS_EN is defined.
module wb_regfile (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        RegWrite_i,
    input  logic        MemToReg_i,
    input  logic [31:0] Data_i,
    input  logic [31:0] Result_i,
    input  logic [4:0]  RD_i,
    input  logic [4:0]  RS_addr_i,
    input  logic [4:0]  RT_addr_i,
    output logic [31:0] RS_data_o,
    output logic [31:0] RT_data_o,
    output logic [31:0] WB_data_o,
    output logic [31:0] written_mask_o,
    output logic [31:0] wr_count_o
);

    logic [31:0] r_regs [32];
    logic [31:0] r_written_mask;
    logic [31:0] r_wr_count;

    logic [31:0] w_wb_data;
    logic        w_commit;
    logic [31:0] w_rs_stored;
    logic [31:0] w_rt_stored;

    assign w_wb_data = MemToReg_i ? Data_i : Result_i;
    assign WB_data_o = w_wb_data;

    // Reset gates commits through the async clear, so the enable needs no rst_n_i term here.
    assign w_commit = RegWrite_i && (RD_i != 5'd0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if (w_commit) begin
            r_regs[RD_i] <= w_wb_data;
        end
    end

    // Bit 0 is hardwired high; only bits 1..31 are real state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_written_mask <= 32'h0000_0001;
        end else if (w_commit) begin
            r_written_mask[RD_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_count <= 32'h0;
        end else if (w_commit) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign written_mask_o = {r_written_mask[31:1], 1'b1};
    assign wr_count_o     = r_wr_count;

    assign w_rs_stored = (RS_addr_i == 5'd0) ? 32'h0 : r_regs[RS_addr_i];
    assign w_rt_stored = (RT_addr_i == 5'd0) ? 32'h0 : r_regs[RT_addr_i];

`ifdef WB_REGFILE_BYPASS_EN
    logic w_bypass_ok;
    assign w_bypass_ok = w_commit && rst_n_i;
    assign RS_data_o = (w_bypass_ok && (RS_addr_i == RD_i)) ? w_wb_data : w_rs_stored;
    assign RT_data_o = (w_bypass_ok && (RT_addr_i == RD_i)) ? w_wb_data : w_rt_stored;
`else
    assign RS_data_o = w_rs_stored;
    assign RT_data_o = w_rt_stored;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expected values are hand-computed constants.
module tb_wb_regfile;

    logic        clk_i;
    logic        rst_n_i;
    logic        RegWrite_i;
    logic        MemToReg_i;
    logic [31:0] Data_i;
    logic [31:0] Result_i;
    logic [4:0]  RD_i;
    logic [4:0]  RS_addr_i;
    logic [4:0]  RT_addr_i;
    logic [31:0] RS_data_o;
    logic [31:0] RT_data_o;
    logic [31:0] WB_data_o;
    logic [31:0] written_mask_o;
    logic [31:0] wr_count_o;

    int n_checks;
    int n_fails;

    wb_regfile dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .RegWrite_i     (RegWrite_i),
        .MemToReg_i     (MemToReg_i),
        .Data_i         (Data_i),
        .Result_i       (Result_i),
        .RD_i           (RD_i),
        .RS_addr_i      (RS_addr_i),
        .RT_addr_i      (RT_addr_i),
        .RS_data_o      (RS_data_o),
        .RT_data_o      (RT_data_o),
        .WB_data_o      (WB_data_o),
        .written_mask_o (written_mask_o),
        .wr_count_o     (wr_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end else begin
            $display("ok   %s: %08h", tag, act);
        end
    endtask

    // One committed write: drive at negedge, commit on posedge, drop enable just after.
    task automatic commit_write(input logic [4:0] rd, input logic [31:0] val, input logic mem);
        @(negedge clk_i);
        RegWrite_i = 1'b1;
        MemToReg_i = mem;
        Data_i     = mem ? val : ~val;
        Result_i   = mem ? ~val : val;
        RD_i       = rd;
        @(posedge clk_i);
        #1;
        RegWrite_i = 1'b0;
    endtask

    task automatic read_both(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        RS_addr_i = addr;
        RT_addr_i = addr;
        #1;
        check_eq({tag, "_rs"}, RS_data_o, exp);
        check_eq({tag, "_rt"}, RT_data_o, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst_n_i    = 1'b0;
        RegWrite_i = 1'b0;
        MemToReg_i = 1'b0;
        Data_i     = 32'h0;
        Result_i   = 32'h0;
        RD_i       = 5'd0;
        RS_addr_i  = 5'd0;
        RT_addr_i  = 5'd0;

        // Reset state across every index
        #2;
        for (int i = 0; i < 32; i++) begin
            RS_addr_i = 5'(i);
            RT_addr_i = 5'(31 - i);
            #1;
            check_eq($sformatf("rst_rs%0d", i), RS_data_o, 32'h0);
            check_eq($sformatf("rst_rt%0d", 31 - i), RT_data_o, 32'h0);
        end
        check_eq("rst_mask", written_mask_o, 32'h0000_0001);
        check_eq("rst_count", wr_count_o, 32'h0);

        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Write-back mux is combinational
        Data_i = 32'hCAFE_0001; Result_i = 32'h0BAD_0002; MemToReg_i = 1'b1;
        #1; check_eq("wb_sel_data", WB_data_o, 32'hCAFE_0001);
        MemToReg_i = 1'b0;
        #1; check_eq("wb_sel_result", WB_data_o, 32'h0BAD_0002);

        // Load-data write to r5
        @(negedge clk_i);
        RegWrite_i = 1'b1; MemToReg_i = 1'b1;
        Data_i = 32'hDEAD_BEEF; Result_i = 32'h1234_5678; RD_i = 5'd5;
        @(posedge clk_i); #1;
        RegWrite_i = 1'b0;
        read_both("r5_load", 5'd5, 32'hDEAD_BEEF);
        check_eq("mask_r5", written_mask_o, 32'h0000_0021);
        check_eq("count_1", wr_count_o, 32'd1);

        // Write to r0 is ignored
        @(negedge clk_i);
        RegWrite_i = 1'b1; MemToReg_i = 1'b0; Result_i = 32'hFFFF_FFFF; RD_i = 5'd0;
        @(posedge clk_i); #1;
        RegWrite_i = 1'b0;
        read_both("r0_after_wr", 5'd0, 32'h0);
        check_eq("count_r0_wr", wr_count_o, 32'd1);
        check_eq("mask_r0_wr", written_mask_o, 32'h0000_0021);

        // Same-cycle read of a register being written
        commit_write(5'd7, 32'h0000_0001, 1'b0);
        check_eq("count_2", wr_count_o, 32'd2);
        @(negedge clk_i);
        RegWrite_i = 1'b1; MemToReg_i = 1'b0; Result_i = 32'hA5A5_A5A5; Data_i = 32'h0; RD_i = 5'd7;
        RT_addr_i = 5'd7; RS_addr_i = 5'd5;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        check_eq("r7_same_cycle", RT_data_o, 32'hA5A5_A5A5);
`else
        check_eq("r7_same_cycle", RT_data_o, 32'h0000_0001);
`endif
        check_eq("r5_unaffected", RS_data_o, 32'hDEAD_BEEF);
        @(posedge clk_i); #1;
        RegWrite_i = 1'b0;
        check_eq("r7_next_cycle", RT_data_o, 32'hA5A5_A5A5);
        check_eq("count_3", wr_count_o, 32'd3);
        check_eq("mask_r7", written_mask_o, 32'h0000_00A1);

        // Back-to-back commits to r9: both counted, last wins
        @(negedge clk_i);
        RegWrite_i = 1'b1; MemToReg_i = 1'b0; Result_i = 32'h0000_0111; RD_i = 5'd9;
        @(negedge clk_i);
        Result_i = 32'h0000_0222;
        @(posedge clk_i); #1;
        RegWrite_i = 1'b0;
        read_both("r9_last_wins", 5'd9, 32'h0000_0222);
        check_eq("count_5", wr_count_o, 32'd5);
        check_eq("mask_r9", written_mask_o, 32'h0000_02A1);
        read_both("r5_kept", 5'd5, 32'hDEAD_BEEF);

        // Counter wraps from all-ones
        @(negedge clk_i);
        dut.r_wr_count = 32'hFFFF_FFFF;
        #1; check_eq("count_preload", wr_count_o, 32'hFFFF_FFFF);
        commit_write(5'd10, 32'h0000_00AA, 1'b1);
        check_eq("count_wrap", wr_count_o, 32'h0);
        read_both("r10", 5'd10, 32'h0000_00AA);

        // Reset mid-cycle with a pending write to r3
        @(negedge clk_i);
        RegWrite_i = 1'b1; MemToReg_i = 1'b0; Result_i = 32'h0000_0077; RD_i = 5'd3;
        #2;
        rst_n_i = 1'b0;
        RS_addr_i = 5'd5; RT_addr_i = 5'd3;
        #1;
        check_eq("arst_r5", RS_data_o, 32'h0);
        check_eq("arst_r3", RT_data_o, 32'h0);
        check_eq("arst_mask", written_mask_o, 32'h0000_0001);
        check_eq("arst_count", wr_count_o, 32'h0);
        check_eq("arst_wb_data", WB_data_o, 32'h0000_0077);
        @(posedge clk_i); #1;
        check_eq("rst_edge_r3", RT_data_o, 32'h0);
        check_eq("rst_edge_count", wr_count_o, 32'h0);
        @(negedge clk_i);
        RegWrite_i = 1'b0;
        rst_n_i    = 1'b1;
        @(posedge clk_i); #1;
        read_both("post_rst_r3", 5'd3, 32'h0);
        check_eq("post_rst_count", wr_count_o, 32'h0);
        commit_write(5'd3, 32'h0000_0077, 1'b0);
        read_both("r3_first_commit", 5'd3, 32'h0000_0077);
        check_eq("count_after_rst", wr_count_o, 32'd1);
        check_eq("mask_after_rst", written_mask_o, 32'h0000_0009);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
